// File: rtl/thd_ram_reader_if.sv
// Bus between the THD read-side controller and its environment:
// spectrum RAM read port plus the start/busy/done control and result fields.
`timescale 1ns/1ps
interface thd_ram_reader_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32,
   parameter int SUM_W  = DATA_W + 4
);
   // Protocol: start is a one-cycle pulse honoured only while busy=0; busy rises
   // the cycle after acceptance and falls with the single-cycle done pulse, from
   // which fund_*/harm_* are valid and held until the next accepted start.
   // rd_data must carry the word at rd_addr in the cycle after rd_addr changes.
   logic              start;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] fund_idx;
   logic [DATA_W-1:0] fund_power;
   logic [SUM_W-1:0]  harm_sum;
   logic [3:0]        harm_cnt;

   modport master (
      input  start, rd_data,
      output rd_addr, busy, done, fund_idx, fund_power, harm_sum, harm_cnt
   );

   modport slave (
      output start, rd_data,
      input  rd_addr, busy, done, fund_idx, fund_power, harm_sum, harm_cnt
   );
endinterface

// File: rtl/thd_ram_reader.sv
// Drains the THD spectrum RAM: finds the fundamental in the lower half-spectrum
// (DC excluded) and accumulates the power of its harmonics 2..NUM_HARM.
`timescale 1ns/1ps
module thd_ram_reader #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int NUM_HARM = 5,
   parameter int SUM_W    = DATA_W + 4
) (
   input  logic             rd_clk,
   input  logic             rd_rst,
   thd_ram_reader_if.master bus,
   output logic [2:0]       dbg_state
);
   localparam int HALF  = 2 ** (ADDR_W - 1);
   localparam int TGT_W = ADDR_W + 4;

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_SCAN_FLUSH, S_HMUL, S_HARM, S_HARM_FLUSH, S_DONE
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] max_idx;
   logic [DATA_W-1:0] max_val;
   logic [3:0]        h;
   logic [TGT_W-1:0]  target;

   logic              last_scan;
   logic              take;
   logic [ADDR_W-1:0] cand_idx;
   logic [DATA_W-1:0] cand_val;
   logic              harm_stop;

   assign dbg_state = state;

   // During SCAN the word on rd_data belongs to the address still held in rd_addr.
   assign last_scan = (bus.rd_addr == ADDR_W'(HALF - 1));
   assign take      = (bus.rd_data > max_val);
   assign cand_idx  = take ? bus.rd_addr : max_idx;
   assign cand_val  = take ? bus.rd_data : max_val;
   assign harm_stop = (target >= TGT_W'(HALF)) || (h > 4'(NUM_HARM));

   always_ff @(posedge rd_clk) begin
      if (rd_rst) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:       if (bus.start) state_next = S_SCAN;
         S_SCAN:       if (last_scan) state_next = S_SCAN_FLUSH;
         S_SCAN_FLUSH: state_next = S_HMUL;
         S_HMUL: begin
            if (harm_stop)                 state_next = S_DONE;
            else if (h == 4'(NUM_HARM))    state_next = S_HARM_FLUSH;
            else                           state_next = S_HARM;
         end
         S_HARM:       state_next = S_HMUL;
         S_HARM_FLUSH: state_next = S_DONE;
         S_DONE:       state_next = S_IDLE;
         default:      state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         bus.rd_addr    <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.fund_idx   <= '0;
         bus.fund_power <= '0;
         bus.harm_sum   <= '0;
         bus.harm_cnt   <= '0;
         max_idx        <= '0;
         max_val        <= '0;
         h              <= '0;
         target         <= '0;
      end else begin
         bus.done <= (state_next == S_DONE);
         if (state_next == S_DONE) bus.busy <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  bus.rd_addr <= ADDR_W'(1);
                  bus.busy    <= 1'b1;
                  max_val     <= '0;
                  max_idx     <= ADDR_W'(1);
               end
            end
            S_SCAN: begin
               max_idx <= cand_idx;
               max_val <= cand_val;
               if (!last_scan) bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
            end
            S_SCAN_FLUSH: begin
               bus.fund_idx   <= cand_idx;
               bus.fund_power <= cand_val;
               bus.harm_sum   <= '0;
               bus.harm_cnt   <= '0;
               h              <= 4'd2;
               target         <= TGT_W'(cand_idx) + TGT_W'(cand_idx);
            end
            S_HMUL: begin
               if (!harm_stop) bus.rd_addr <= target[ADDR_W-1:0];
            end
            // Both states consume the word read in the preceding HMUL cycle.
            S_HARM, S_HARM_FLUSH: begin
               bus.harm_sum <= bus.harm_sum + SUM_W'(bus.rd_data);
               bus.harm_cnt <= bus.harm_cnt + 4'd1;
               h            <= h + 4'd1;
               target       <= target + TGT_W'(bus.fund_idx);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_thd_ram_reader.sv
// Self-checking bench for thd_ram_reader: table of directed spectra, random
// spectra against a reference model, and start/reset control hazards.
`timescale 1ns/1ps
module tb_thd_ram_reader;
   localparam int ADDR_W   = 11;
   localparam int DATA_W   = 32;
   localparam int NUM_HARM = 5;
   localparam int SUM_W    = DATA_W + 4;
   localparam int N        = 2 ** ADDR_W;
   localparam int HALF     = N / 2;
   localparam int RES_W    = ADDR_W + DATA_W + SUM_W + 4;
   localparam int BUDGET   = 4000;

   typedef struct {
      string             name;
      int                pat;
      bit                hazard;
      logic [ADDR_W-1:0] f_idx;
      logic [DATA_W-1:0] f_pow;
      logic [SUM_W-1:0]  h_sum;
      logic [3:0]        h_cnt;
   } vec_t;

   logic       rd_clk = 1'b0;
   logic       rd_rst = 1'b1;
   logic [2:0] dbg_state;
   int         n_checks = 0;
   int         n_errors = 0;

   logic [DATA_W-1:0] mem [N];
   logic [RES_W-1:0]  exp_q [$];
   vec_t              vecs [5];

   thd_ram_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

   thd_ram_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_HARM(NUM_HARM), .SUM_W(SUM_W)
   ) dut (
      .rd_clk    (rd_clk),
      .rd_rst    (rd_rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock; RAM read port with its address register being rd_addr
   always #5 rd_clk = ~rd_clk;
   assign bus.rd_data = mem[bus.rd_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: strict-max peak over bins 1..HALF-1, then harmonics while in range.
   function automatic logic [RES_W-1:0] model();
      int                f = 1;
      logic [DATA_W-1:0] fp = '0;
      logic [SUM_W-1:0]  sum = '0;
      int                cnt = 0;
      for (int i = 1; i < HALF; i++)
         if (mem[i] > fp) begin
            fp = mem[i];
            f  = i;
         end
      for (int hh = 2; hh <= NUM_HARM; hh++) begin
         if (hh * f >= HALF) break;
         sum = sum + SUM_W'(mem[hh * f]);
         cnt++;
      end
      return {ADDR_W'(f), fp, sum, 4'(cnt)};
   endfunction

   task automatic fill(input int pat);
      int f;
      for (int i = 0; i < N; i++) mem[i] = '0;
      case (pat)
         0: begin mem[100] = 1000; mem[200] = 100; mem[300] = 50; mem[400] = 25; mem[500] = 10; end
         1: begin mem[300] = 5000; mem[600] = 7; mem[900] = 3; mem[1200] = 77; mem[1500] = 88; end
         2: begin mem[0] = 9999; mem[50] = 400; mem[70] = 400; end
         3: for (int i = 0; i < N; i++) mem[i] = 32'hFFFF_FFFF;
         4: ;
         5: for (int i = 0; i < N; i++) mem[i] = $urandom;
         default: begin
            for (int i = 0; i < N; i++) mem[i] = $urandom_range(0, 1000);
            f = $urandom_range(1, 300);
            mem[f] = 32'd100000 + $urandom_range(0, 5000);
         end
      endcase
   endtask

   task automatic run_and_check(input string tag, input bit hazard);
      logic [RES_W-1:0]  e;
      logic [ADDR_W-1:0] max_a;
      int                cycles;
      bit                busy_ok;
      @(negedge rd_clk);
      bus.start = 1'b1;
      @(negedge rd_clk);
      bus.start = 1'b0;
      cycles  = 0;
      busy_ok = 1'b1;
      max_a   = '0;
      while (bus.done !== 1'b1 && cycles < BUDGET) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (bus.rd_addr > max_a) max_a = bus.rd_addr;
         bus.start = hazard && ($urandom_range(0, 15) == 0);
         @(negedge rd_clk);
         cycles++;
      end
      bus.start = 1'b0;
      check({tag, ".done_seen"}, 64'(cycles < BUDGET), 64'd1);
      check({tag, ".busy_during"}, 64'(busy_ok), 64'd1);
      check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
      check({tag, ".max_rd_addr_in_half"}, 64'(max_a < ADDR_W'(HALF)), 64'd1);
      e = exp_q.pop_front();
      check({tag, ".fund_idx"},   64'(bus.fund_idx),   64'(e[RES_W-1 -: ADDR_W]));
      check({tag, ".fund_power"}, 64'(bus.fund_power), 64'(e[SUM_W+4 +: DATA_W]));
      check({tag, ".harm_sum"},   64'(bus.harm_sum),   64'(e[4 +: SUM_W]));
      check({tag, ".harm_cnt"},   64'(bus.harm_cnt),   64'(e[3:0]));
      // start coinciding with done must not launch another run
      if (hazard) bus.start = 1'b1;
      @(negedge rd_clk);
      bus.start = 1'b0;
      check({tag, ".done_one_cycle"}, 64'(bus.done), 64'd0);
      @(negedge rd_clk);
      check({tag, ".idle_after"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      vecs[0] = '{"tone",    0, 1'b1, 11'd100, 32'd1000,        36'd185,           4'd4};
      vecs[1] = '{"cutoff",  1, 1'b0, 11'd300, 32'd5000,        36'd10,            4'd2};
      vecs[2] = '{"tie_dc",  2, 1'b0, 11'd50,  32'd400,         36'd0,             4'd4};
      vecs[3] = '{"sat",     3, 1'b0, 11'd1,   32'hFFFF_FFFF,   36'h3_FFFF_FFFC,   4'd4};
      vecs[4] = '{"zero",    4, 1'b1, 11'd1,   32'd0,           36'd0,             4'd4};

      // reset block
      fill(4);
      repeat (3) @(negedge rd_clk);
      check("rst.rd_addr",    64'(bus.rd_addr),    64'd0);
      check("rst.busy",       64'(bus.busy),       64'd0);
      check("rst.done",       64'(bus.done),       64'd0);
      check("rst.fund_idx",   64'(bus.fund_idx),   64'd0);
      check("rst.fund_power", 64'(bus.fund_power), 64'd0);
      check("rst.harm_sum",   64'(bus.harm_sum),   64'd0);
      check("rst.harm_cnt",   64'(bus.harm_cnt),   64'd0);
      rd_rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         fill(vecs[v].pat);
         exp_q.push_back({vecs[v].f_idx, vecs[v].f_pow, vecs[v].h_sum, vecs[v].h_cnt});
         run_and_check(vecs[v].name, vecs[v].hazard);
      end

      for (int r = 0; r < 4; r++) begin
         fill(5 + (r % 2));
         exp_q.push_back(model());
         run_and_check($sformatf("rand%0d", r), r[0]);
      end

      // reset in the middle of SCAN
      begin
         bit done_seen;
         fill(0);
         @(negedge rd_clk);
         bus.start = 1'b1;
         @(negedge rd_clk);
         bus.start = 1'b0;
         repeat (20) @(negedge rd_clk);
         check("midrst.busy_before", 64'(bus.busy), 64'd1);
         rd_rst = 1'b1;
         @(negedge rd_clk);
         rd_rst = 1'b0;
         check("midrst.busy",       64'(bus.busy),       64'd0);
         check("midrst.done",       64'(bus.done),       64'd0);
         check("midrst.rd_addr",    64'(bus.rd_addr),    64'd0);
         check("midrst.fund_idx",   64'(bus.fund_idx),   64'd0);
         check("midrst.fund_power", 64'(bus.fund_power), 64'd0);
         check("midrst.harm_sum",   64'(bus.harm_sum),   64'd0);
         check("midrst.harm_cnt",   64'(bus.harm_cnt),   64'd0);
         done_seen = 1'b0;
         for (int c = 0; c < 1200; c++) begin
            @(negedge rd_clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
         end
         check("midrst.no_activity", 64'(done_seen), 64'd0);
         exp_q.push_back({11'd100, 32'd1000, 36'd185, 4'd4});
         run_and_check("after_rst", 1'b0);
      end

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/thd_ram_reader.md
Name: thd_ram_reader

Overview:
- Read-side controller for the 2048x32 THD spectrum RAM; the FFT path fills the RAM through the write port, and this block drains it through the read port.
- After a start pulse it scans the lower half-spectrum to find the fundamental (peak bin, DC excluded).
- It then reads the bins at integer multiples of the fundamental and accumulates harmonic power.
- Results feed the THD ratio/divider stage and the display register bank.

Parameters:
- ADDR_W, 11, RAM address width; spectrum length N = 2^ADDR_W; scanned half HALF = 2^(ADDR_W-1).
- DATA_W, 32, RAM word width; each word is an unsigned bin power.
- NUM_HARM, 5, highest harmonic order accumulated (orders 2..NUM_HARM); legal range 2..9.
- SUM_W, DATA_W+4, harmonic accumulator width.

Ports:
- rd_clk  in  1  single clock; RAM read clock and block clock.
- rd_rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins analysis; ignored while busy=1.
- rd_addr  out  ADDR_W  registered RAM read address.
- rd_data  in  DATA_W  RAM read data; valid the cycle after rd_addr is registered (RAM OUTPUT_REG=0).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid and held from this cycle.
- fund_idx  out  ADDR_W  bin index of the fundamental.
- fund_power  out  DATA_W  power at fund_idx.
- harm_sum  out  SUM_W  sum of harmonic bin powers.
- harm_cnt  out  4  number of harmonics actually accumulated.

Behaviour:
- Reset (rd_rst=1 at a rising edge) values: rd_addr=0, busy=0, done=0, fund_idx=0, fund_power=0, harm_sum=0, harm_cnt=0. State goes to IDLE.
- Reset mid-operation aborts the run with no done pulse.
- Read timing: the address registered at edge t has its data sampled at edge t+1. One read is issued per cycle, with no stalls.
- FSM states: IDLE, SCAN, SCAN_FLUSH, HMUL, HARM, HARM_FLUSH, DONE.
- IDLE:
  - start=1 -> SCAN; rd_addr<=1; busy<=1; running max cleared to 0; max index set to 1.
  - Outputs keep their previous results.
- SCAN:
  - rd_addr increments 1..HALF-1.
  - Each returned word is compared with the running max. Replace only on strictly greater, so on ties the lowest index wins.
  - After HALF-1 has been issued -> SCAN_FLUSH, which consumes the last word.
- SCAN_FLUSH -> HMUL:
  - fund_idx and fund_power are latched from the running max.
  - Harmonic order h=2; accumulator and count cleared.
- HMUL:
  - Computes target = h*fund_idx at full width (ADDR_W+4 bits), by repeated addition of fund_idx (no multiplier).
  - If target >= HALF or h > NUM_HARM -> DONE with no further reads; otherwise rd_addr<=target -> HARM.
- HARM:
  - The next cycle's data is added to harm_sum (no overflow possible at SUM_W); harm_cnt increments.
  - Then h increments -> HMUL.
  - HARM_FLUSH is used only to absorb the final read's latency.
- DONE: done=1 for exactly one cycle, busy<=0 the same edge, -> IDLE.
- All-zero spectrum: fund_idx=1, fund_power=0. Harmonics are still read.
- start asserted in the same cycle done is high is ignored. start is accepted only in IDLE.
- rd_data is ignored in every cycle other than the one after an issued read.

Test Plan:
- Tone run: bin100=1000, bin200=100, bin300=50, bin400=25, bin500=10, all other bins 0; pulse start -> fund_idx=100, fund_power=1000, harm_sum=185, harm_cnt=4, one done pulse; busy high throughout the run.
- Harmonic cutoff: fundamental at bin300=5000, bin600=7, bin900=3 -> harm_sum=10, harm_cnt=2. No read is issued at address 1200 or above.
- Tie and DC exclusion: bin0=9999, bin50=bin70=400 -> fund_idx=50, fund_power=400.
- Saturated data: every bin = 0xFFFFFFFF -> fund_idx=1, harmonic bins 2..5 read, harm_sum=0x3_FFFF_FFFC, harm_cnt=4.
- All-zero RAM -> fund_idx=1, fund_power=0, harm_sum=0, harm_cnt=4.
- Control hazards:
  - start pulses during busy are ignored; results match a single run.
  - rd_rst asserted mid-SCAN -> next edge busy=0, all outputs 0, no done pulse.
  - A new start after the reset completes normally.
